// File: rtl/apb_to_obi_if.sv
// APB-slave / OBI-manager signal bundle for apb_to_obi.
// Signal names follow the bridge's point of view (_i into the bridge, _o out of it).
// The slave modport is the bridge; the master modport is whatever drives APB and
// answers on OBI.
interface apb_to_obi_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    // APB side
    logic [AddrWidth-1:0]   paddr_i;
    logic                   psel_i;
    logic                   penable_i;
    logic                   pwrite_i;
    logic [DataWidth-1:0]   pwdata_i;
    logic [DataWidth/8-1:0] pstrb_i;
    logic                   pready_o;
    logic [DataWidth-1:0]   prdata_o;
    logic                   pslverr_o;

    // OBI side
    logic                   obi_req_o;
    logic                   obi_gnt_i;
    logic [AddrWidth-1:0]   obi_addr_o;
    logic                   obi_we_o;
    logic [DataWidth/8-1:0] obi_be_o;
    logic [DataWidth-1:0]   obi_wdata_o;
    logic                   obi_rvalid_i;
    logic [DataWidth-1:0]   obi_rdata_i;
    logic                   obi_err_i;

    modport slave (
        input  paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        output pready_o, prdata_o, pslverr_o,
        output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o
    );

    modport master (
        output paddr_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        input  pready_o, prdata_o, pslverr_o,
        input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o
    );
endinterface

// File: rtl/apb_to_obi.sv
// APB slave to OBI manager bridge, one outstanding OBI transaction at a time.
// Optional feature macro: APB_TO_OBI_TIMEOUT_EN adds a response watchdog and a
// DRAIN state that swallows the late OBI response after a timeout.
module apb_to_obi #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input logic         clk_i,
    input logic         rst_ni,
    apb_to_obi_if.slave bus
);
    localparam int unsigned StrbWidth = DataWidth / 8;

`ifdef APB_TO_OBI_TIMEOUT_EN
    typedef enum logic [2:0] {StIdle, StReq, StRsp, StDone, StDrain} state_e;
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] cnt_d, cnt_q;
`else
    typedef enum logic [2:0] {StIdle, StReq, StRsp, StDone} state_e;
    // Watchdog absent in this build; parameter intentionally unused.
    logic unused_timeout;
    assign unused_timeout = ^TimeoutCycles;
`endif

    state_e                 state_d, state_q;
    logic [AddrWidth-1:0]   addr_d, addr_q;
    logic                   we_d, we_q;
    logic [StrbWidth-1:0]   be_d, be_q;
    logic [DataWidth-1:0]   wdata_d, wdata_q;
    logic                   pready_d, pready_q;
    logic [DataWidth-1:0]   prdata_d, prdata_q;
    logic                   pslverr_d, pslverr_q;

    // Next-state and response logic; pready/pslverr default low so they pulse for one cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
`ifdef APB_TO_OBI_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                // Only a setup phase starts a transfer; access phases seen here are ignored.
                if (bus.psel_i && !bus.penable_i) begin
                    addr_d  = bus.paddr_i;
                    we_d    = bus.pwrite_i;
                    be_d    = bus.pwrite_i ? bus.pstrb_i : {StrbWidth{1'b1}};
                    wdata_d = bus.pwrite_i ? bus.pwdata_i : '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.obi_gnt_i) begin
                    state_d = StRsp;
`ifdef APB_TO_OBI_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StRsp: begin
                if (bus.obi_rvalid_i) begin
                    prdata_d  = we_q ? '0 : bus.obi_rdata_i;
                    pslverr_d = bus.obi_err_i;
                    pready_d  = 1'b1;
                    state_d   = StDone;
                end
`ifdef APB_TO_OBI_TIMEOUT_EN
                else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    // Report the timeout on APB, then wait out the OBI response in DRAIN.
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    pready_d  = 1'b1;
                    state_d   = StDrain;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
`ifdef APB_TO_OBI_TIMEOUT_EN
            StDrain: begin
                if (bus.obi_rvalid_i) begin
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered A-channel / APB response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
`ifdef APB_TO_OBI_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
`ifdef APB_TO_OBI_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Request is a direct decode of the state flop, so it drops as soon as reset asserts.
    assign bus.obi_req_o   = (state_q == StReq);
    assign bus.obi_addr_o  = addr_q;
    assign bus.obi_we_o    = we_q;
    assign bus.obi_be_o    = be_q;
    assign bus.obi_wdata_o = wdata_q;
    assign bus.pready_o    = pready_q;
    assign bus.prdata_o    = prdata_q;
    assign bus.pslverr_o   = pslverr_q;
endmodule

// File: tb/tb_apb_to_obi.sv
// Self-checking bench for apb_to_obi: randomized APB transfers against an OBI
// responder with chosen grant/response delays; expectations come from the
// transfer-level timing and data rules. Define APB_TO_OBI_TIMEOUT_EN to add the watchdog test.
module tb_apb_to_obi;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_to_obi_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    apb_to_obi #(
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int            req_cycles;
        bit            a_stable;
        logic [AW-1:0] addr;
        logic          we;
        logic [SW-1:0] be;
        logic [DW-1:0] wdata;
        int            gnt_cnt;
        bit            overlap;
        int            pready_cyc;
        logic [DW-1:0] prdata;
        logic          pslverr;
        logic          pready_after;
        logic          pslverr_after;
    } obs_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            gd;
        int            rd;
        logic [DW-1:0] rdata;
        logic          err;
    } txn_t;

    task automatic idle_inputs();
        bus.paddr_i      = '0;
        bus.psel_i       = 1'b0;
        bus.penable_i    = 1'b0;
        bus.pwrite_i     = 1'b0;
        bus.pwdata_i     = '0;
        bus.pstrb_i      = '0;
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = '0;
        bus.obi_err_i    = 1'b0;
    endtask

    // Runs one APB transfer starting at the current negedge (cycle 0 = setup) and acts as
    // the OBI responder: grant after gd waiting cycles, rvalid rd cycles after the grant.
    // Returns at the negedge after pready with everything observed.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] strb, input int gd, input int rd,
                        input logic [DW-1:0] rdata, input logic err, input bit drop_psel,
                        output obs_t o);
        int gnt_cyc;
        bit granted;
        bit done;
        o = '{default: '0};
        o.a_stable   = 1'b1;
        o.pready_cyc = -1;
        gnt_cyc      = -1;
        granted      = 1'b0;
        done         = 1'b0;
        bus.psel_i       = 1'b1;
        bus.penable_i    = 1'b0;
        bus.pwrite_i     = wr;
        bus.paddr_i      = addr;
        bus.pwdata_i     = wdata;
        bus.pstrb_i      = strb;
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge clk);
            if (drop_psel) begin
                bus.psel_i    = 1'b0;
                bus.penable_i = 1'b0;
            end else begin
                bus.penable_i = 1'b1;
            end
            if (bus.pready_o) begin
                o.pready_cyc     = c;
                o.prdata         = bus.prdata_o;
                o.pslverr        = bus.pslverr_o;
                bus.psel_i       = 1'b0;
                bus.penable_i    = 1'b0;
                bus.obi_gnt_i    = 1'b0;
                bus.obi_rvalid_i = 1'b0;
                @(negedge clk);
                o.pready_after  = bus.pready_o;
                o.pslverr_after = bus.pslverr_o;
                if (bus.obi_req_o) o.overlap = 1'b1;
                done = 1'b1;
            end else begin
                if (bus.obi_req_o) begin
                    if (granted) o.overlap = 1'b1;
                    o.req_cycles++;
                    if (o.req_cycles == 1) begin
                        o.addr  = bus.obi_addr_o;
                        o.we    = bus.obi_we_o;
                        o.be    = bus.obi_be_o;
                        o.wdata = bus.obi_wdata_o;
                    end else if ({o.addr, o.we, o.be, o.wdata} !==
                                 {bus.obi_addr_o, bus.obi_we_o, bus.obi_be_o, bus.obi_wdata_o}) begin
                        o.a_stable = 1'b0;
                    end
                end
                bus.obi_gnt_i = bus.obi_req_o && !granted && (o.req_cycles == gd + 1);
                if (bus.obi_gnt_i) begin
                    granted = 1'b1;
                    gnt_cyc = c;
                    o.gnt_cnt++;
                end
                bus.obi_rvalid_i = granted && (c == gnt_cyc + 1 + rd);
                bus.obi_rdata_i  = bus.obi_rvalid_i ? rdata : $urandom();
                bus.obi_err_i    = bus.obi_rvalid_i ? err : 1'($urandom_range(0, 1));
            end
        end
        if (!done) idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.obi_req_o, bus.obi_we_o, bus.pready_o, bus.pslverr_o} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got req/we/pready/pslverr=%b expected 0000",
                     {bus.obi_req_o, bus.obi_we_o, bus.pready_o, bus.pslverr_o});
        end
        tests_run++;
        if (bus.obi_addr_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_addr: got %h expected 0", bus.obi_addr_o);
        end
        tests_run++;
        if ({bus.obi_be_o, bus.obi_wdata_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_be_wdata: got be=%h wdata=%h expected 0", bus.obi_be_o, bus.obi_wdata_o);
        end
        tests_run++;
        if (bus.prdata_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_prdata: got %h expected 0", bus.prdata_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        obs_t o;
        xfer(1'b0, 32'h0000_1004, $urandom(), 4'($urandom()), 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, o);
        tests_run++;
        if ({o.addr, o.we, o.be, o.wdata} !== {32'h0000_1004, 1'b0, 4'hF, 32'h0}) begin
            tests_failed++;
            $display("FAIL read_achan: got addr=%h we=%b be=%h wdata=%h expected 00001004/0/f/0",
                     o.addr, o.we, o.be, o.wdata);
        end
        tests_run++;
        if (o.pready_cyc !== 3) begin
            tests_failed++;
            $display("FAIL read_latency: got pready at cycle %0d expected 3", o.pready_cyc);
        end
        tests_run++;
        if ({o.prdata, o.pslverr} !== {32'hDEAD_BEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL read_resp: got prdata=%h pslverr=%b expected deadbeef/0", o.prdata, o.pslverr);
        end
        tests_run++;
        if (o.pready_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_pready_pulse: got pready=%b after DONE expected 0", o.pready_after);
        end
    endtask

    task automatic test_write();
        obs_t o;
        xfer(1'b1, 32'h0000_2000, 32'h1234_5678, 4'h3, 4, 1, $urandom(), 1'b0, 1'b0, o);
        tests_run++;
        if (o.req_cycles !== 5 || !o.a_stable) begin
            tests_failed++;
            $display("FAIL write_req_hold: got %0d req cycles stable=%b expected 5 stable=1",
                     o.req_cycles, o.a_stable);
        end
        tests_run++;
        if ({o.addr, o.we, o.be, o.wdata} !== {32'h0000_2000, 1'b1, 4'h3, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL write_achan: got addr=%h we=%b be=%h wdata=%h expected 00002000/1/3/12345678",
                     o.addr, o.we, o.be, o.wdata);
        end
        tests_run++;
        if (o.pready_cyc !== 8) begin
            tests_failed++;
            $display("FAIL write_latency: got pready at cycle %0d expected 8", o.pready_cyc);
        end
        tests_run++;
        if ({o.prdata, o.pslverr} !== {32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL write_resp: got prdata=%h pslverr=%b expected 0/0", o.prdata, o.pslverr);
        end
    endtask

    task automatic test_error();
        obs_t o;
        for (int i = 0; i < 2; i++) begin
            int gd = $urandom_range(0, 3);
            int rd = $urandom_range(0, 3);
            logic [DW-1:0] rdata = $urandom();
            bit wr = (i == 1);
            xfer(wr, $urandom(), $urandom(), 4'($urandom()), gd, rd, rdata, 1'b1, 1'b0, o);
            tests_run++;
            if ({o.pready_cyc, o.pslverr} !== {3 + gd + rd, 1'b1}) begin
                tests_failed++;
                $display("FAIL error_resp[%0d]: got pready cycle %0d pslverr=%b expected %0d/1",
                         i, o.pready_cyc, o.pslverr, 3 + gd + rd);
            end
            tests_run++;
            if ({o.pready_after, o.pslverr_after} !== 2'b00) begin
                tests_failed++;
                $display("FAIL error_clear[%0d]: got pready=%b pslverr=%b next cycle expected 0/0",
                         i, o.pready_after, o.pslverr_after);
            end
            tests_run++;
            if (o.prdata !== (wr ? 32'h0 : rdata)) begin
                tests_failed++;
                $display("FAIL error_prdata[%0d]: got %h expected %h", i, o.prdata, wr ? 32'h0 : rdata);
            end
        end
    endtask

    task automatic test_psel_drop();
        obs_t o;
        xfer(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hC, 1, 2, $urandom(), 1'b0, 1'b1, o);
        tests_run++;
        if ({o.gnt_cnt, o.pready_cyc} !== {32'd1, 32'd6}) begin
            tests_failed++;
            $display("FAIL psel_drop: got %0d grants pready cycle %0d expected 1 grant cycle 6",
                     o.gnt_cnt, o.pready_cyc);
        end
        xfer(1'b0, 32'h0000_0044, '0, '0, 0, 0, 32'h0BAD_CAFE, 1'b0, 1'b0, o);
        tests_run++;
        if ({o.pready_cyc, o.prdata} !== {32'd3, 32'h0BAD_CAFE}) begin
            tests_failed++;
            $display("FAIL psel_drop_next: got cycle %0d prdata %h expected 3/0badcafe",
                     o.pready_cyc, o.prdata);
        end
    endtask

    task automatic test_back_to_back();
        txn_t q[$];
        txn_t t;
        obs_t o;
        logic [SW-1:0] exp_be;
        logic [DW-1:0] exp_wdata;
        logic [DW-1:0] exp_prdata;
        for (int i = 0; i < 10; i++) begin
            t.wr    = (i % 2 == 1);
            t.addr  = $urandom();
            t.wdata = $urandom();
            t.strb  = 4'($urandom());
            t.gd    = $urandom_range(0, 3);
            t.rd    = $urandom_range(0, 3);
            t.rdata = $urandom();
            t.err   = 1'($urandom_range(0, 1));
            q.push_back(t);
        end
        for (int i = 0; i < 10; i++) begin
            t = q.pop_front();
            xfer(t.wr, t.addr, t.wdata, t.strb, t.gd, t.rd, t.rdata, t.err, 1'b0, o);
            exp_be     = t.wr ? t.strb : '1;
            exp_wdata  = t.wr ? t.wdata : '0;
            exp_prdata = t.wr ? '0 : t.rdata;
            tests_run++;
            if ({o.addr, o.we, o.be, o.wdata} !== {t.addr, t.wr, exp_be, exp_wdata}) begin
                tests_failed++;
                $display("FAIL b2b_achan[%0d]: got %h/%b/%h/%h expected %h/%b/%h/%h", i,
                         o.addr, o.we, o.be, o.wdata, t.addr, t.wr, exp_be, exp_wdata);
            end
            tests_run++;
            if (!o.a_stable || o.req_cycles != t.gd + 1 || o.gnt_cnt != 1) begin
                tests_failed++;
                $display("FAIL b2b_issue[%0d]: got stable=%b req=%0d gnt=%0d expected 1/%0d/1",
                         i, o.a_stable, o.req_cycles, o.gnt_cnt, t.gd + 1);
            end
            tests_run++;
            if (o.overlap !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_outstanding[%0d]: got request while a response pending, expected none", i);
            end
            tests_run++;
            if (o.pready_cyc != 3 + t.gd + t.rd) begin
                tests_failed++;
                $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, o.pready_cyc, 3 + t.gd + t.rd);
            end
            tests_run++;
            if ({o.prdata, o.pslverr} !== {exp_prdata, t.err}) begin
                tests_failed++;
                $display("FAIL b2b_resp[%0d]: got %h/%b expected %h/%b", i, o.prdata, o.pslverr,
                         exp_prdata, t.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   saw;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = 32'h0000_3000;
        bus.obi_gnt_i = 1'b0;
        @(negedge clk);
        bus.penable_i = 1'b1;
        tests_run++;
        if (bus.obi_req_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_req_before: got req=%b expected 1", bus.obi_req_o);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.obi_req_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_req_drop: got req=%b during reset expected 0", bus.obi_req_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.pready_o !== 1'b0 || bus.obi_req_o !== 1'b0) saw = 1'b1;
            bus.obi_rvalid_i = 1'($urandom_range(0, 1));
        end
        bus.obi_rvalid_i = 1'b0;
        tests_run++;
        if (saw !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_no_resp: got activity after reset release expected none");
        end
        xfer(1'b0, 32'h0000_3004, '0, '0, 1, 1, 32'h5A5A_A5A5, 1'b0, 1'b0, o);
        tests_run++;
        if ({o.pready_cyc, o.prdata, o.addr} !== {32'd5, 32'h5A5A_A5A5, 32'h0000_3004}) begin
            tests_failed++;
            $display("FAIL rstmid_next: got cycle %0d prdata %h addr %h expected 5/5a5aa5a5/00003004",
                     o.pready_cyc, o.prdata, o.addr);
        end
    endtask

`ifdef APB_TO_OBI_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        int   pc;
        bit   bad;
        logic [DW-1:0] pr;
        logic          pe;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.pwrite_i  = 1'b0;
        bus.paddr_i   = 32'h0000_4000;
        @(negedge clk);
        bus.penable_i = 1'b1;
        bus.obi_gnt_i = bus.obi_req_o;
        pc = -1;
        pr = '0;
        pe = 1'b0;
        for (int c = 2; c <= 40 && pc < 0; c++) begin
            @(negedge clk);
            bus.obi_gnt_i = 1'b0;
            if (bus.pready_o) begin
                pc = c;
                pr = bus.prdata_o;
                pe = bus.pslverr_o;
            end
        end
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        // Entered RSP at cycle 2; eight silent RSP cycles then the error response.
        tests_run++;
        if ({pc, pe, pr} !== {32'd10, 1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL timeout_resp: got cycle %0d pslverr %b prdata %h expected 10/1/0", pc, pe, pr);
        end
        bad = 1'b0;
        @(negedge clk);
        if (bus.pready_o !== 1'b0) bad = 1'b1;
        bus.psel_i  = 1'b1;
        bus.paddr_i = 32'h0000_5000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.obi_req_o !== 1'b0 || bus.pready_o !== 1'b0) bad = 1'b1;
            bus.penable_i = (c == 0);
            bus.psel_i    = (c < 2);
        end
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = $urandom();
        @(negedge clk);
        bus.obi_rvalid_i = 1'b0;
        if (bus.obi_req_o !== 1'b0 || bus.pready_o !== 1'b0) bad = 1'b1;
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_drain: got request or pready while draining expected none");
        end
        xfer(1'b0, 32'h0000_6000, '0, '0, 0, 2, 32'h7777_1111, 1'b0, 1'b0, o);
        tests_run++;
        if ({o.pready_cyc, o.prdata, o.pslverr} !== {32'd5, 32'h7777_1111, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_next: got cycle %0d prdata %h pslverr %b expected 5/77771111/0",
                     o.pready_cyc, o.prdata, o.pslverr);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_error();
        test_psel_drop();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_TO_OBI_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
